// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared state enum, widths and default limits for the CAN transmit scheduler
package can_pkg;

  localparam int CAN_WORD_W         = 32;
  localparam int CAN_CNT_W          = 32;
  localparam int CAN_DEF_TX_TIMEOUT = 50000;
  localparam int CAN_DEF_BUSY_WAIT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } can_tx_state_t;

  // Cycle counters stick at all-ones instead of wrapping back to a small value
  function automatic logic [CAN_CNT_W-1:0] sat_inc(input logic [CAN_CNT_W-1:0] v);
    return (&v) ? v : v + CAN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/can_tx_sched_pick.sv
// rtl/can_tx_sched_pick.sv - winner selection; round-robin with CAN_TX_SCHED_RR_EN, else lowest index wins
module can_tx_sched_pick
  import can_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,     // first index searched: one past the last winner
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

`ifdef CAN_TX_SCHED_RR_EN
  // Walk the request vector starting at rr_ptr, wrapping NUM_REQ-1 to 0
  always_comb begin
    int   pos;
    logic found;
    pos       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IDX_W'(pos);
      end
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Fixed priority: scan from the top so the lowest set index is the last to overwrite
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/can_tx_sched.sv
// rtl/can_tx_sched.sv - CAN transmit scheduler: grants one requester at a time onto the CAN core (CAN_TX_SCHED_RR_EN selects round-robin)
module can_tx_sched
  import can_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int TX_TIMEOUT = CAN_DEF_TX_TIMEOUT,
  parameter  int BUSY_WAIT  = CAN_DEF_BUSY_WAIT,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [CAN_WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [CAN_WORD_W-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          done_valid,
  output logic [IDX_W-1:0]              done_idx,
  output logic                          done_err,
  output logic                          busy
);

  localparam logic [CAN_CNT_W-1:0] TX_LIMIT   = CAN_CNT_W'(TX_TIMEOUT);
  localparam logic [CAN_CNT_W-1:0] BUSY_LIMIT = CAN_CNT_W'(BUSY_WAIT);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_REQ - 1);

  can_tx_state_t           state;
  logic [CAN_CNT_W-1:0]    cnt;
  logic [CAN_CNT_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        ptr_nxt;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]      pick_grant;
  logic [CAN_WORD_W-1:0]   sel_data;
  logic                    grant_en;

  can_tx_sched_pick #(
    .NUM_REQ   (NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Payload word of the requester currently winning arbitration
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_data = req_data[CAN_WORD_W*i +: CAN_WORD_W];
      end
    end
  end

  // Next search origin, saturating count including this cycle, and grant qualifier
  always_comb begin
    ptr_nxt  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
    cnt_nxt  = sat_inc(cnt);
    grant_en = tx_ready && (|req_valid);
  end

  // Scheduler FSM; every output is a register so nothing glitches toward requesters or the core
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      win_idx    <= '0;
      req_ready  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      done_valid <= 1'b0;
      done_idx   <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= '0;
      tx_valid   <= 1'b0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A core that is not idle blocks grants even with requests pending
          if (grant_en) begin
            req_ready <= pick_grant;
            tx_data   <= sel_data;
            win_idx   <= pick_idx;
            rr_ptr    <= ptr_nxt;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_valid <= 1'b1;
          cnt      <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Core must acknowledge the issue by dropping tx_ready
          if (!tx_ready) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt_nxt >= BUSY_LIMIT) begin
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            done_idx   <= win_idx;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ST_WAIT_DONE: begin
          // Completion is checked before the timeout so a frame finishing on the last cycle is not aborted
          if (tx_ready) begin
            done_valid <= 1'b1;
            done_err   <= 1'b0;
            done_idx   <= win_idx;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else if (cnt_nxt >= TX_LIMIT) begin
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            done_idx   <= win_idx;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_sched.sv
// tb/tb_can_tx_sched.sv - scoreboard bench for can_tx_sched against a transaction-level model (honours CAN_TX_SCHED_RR_EN)
module tb_can_tx_sched;

  localparam int N  = 4;
  localparam int TO = 100;
  localparam int BW = 16;

  logic            ap_clk;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [31:0]     tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            done_valid;
  logic [1:0]      done_idx;
  logic            done_err;
  logic            busy;

  can_tx_sched #(
    .NUM_REQ    (N),
    .TX_TIMEOUT (TO),
    .BUSY_WAIT  (BW)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done_valid (done_valid),
    .done_idx   (done_idx),
    .done_err   (done_err),
    .busy       (busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          at;
  } xfer_t;

  typedef struct {
    int   idx;
    logic err;
    int   at;
  } done_t;

  xfer_t gq[$];
  xfer_t tq[$];
  done_t dq[$];
  int    mode_q[$];
  int    clog[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          phase = 0;
  int          done_cnt = 0;
  int          last_done_idx = -1;
  logic        last_done_err = 1'b1;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_data = '0;
  logic [N-1:0] ack_seen = '0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Search for the first pending requester beginning at 'start'
  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // How long the core stays busy for the next frame; 0 means it never acknowledges
  function automatic int choose_hold();
    int r;
    case (phase)
      1: return 1 + $urandom_range(0, 2);
      2: return 20;
      4: return 130;
      default: begin
        r = $urandom_range(0, 99);
        if (r < 8)       return 0;
        else if (r < 14) return TO + 1;
        else if (r < 20) return TO - 1;
        else if (r < 26) return $urandom_range(120, 140);
        else             return $urandom_range(1, 30);
      end
    endcase
  endfunction

  // Reference model: one frame at a time; predicts grant, issue and completion cycles
  initial begin : model
    int next_start;
    int free_at;
    int done_at;
    int win;
    int hold;
    int tv;
    int wd_entry;
    logic err;
    logic [31:0] d;
    next_start = 0;
    free_at    = 0;
    done_at    = 0;
    forever begin
      @(posedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        gq.delete(); tq.delete(); dq.delete(); mode_q.delete();
        free_at    = 0;
        exp_busy   = 1'b0;
        exp_data   = '0;
        next_start = 0;
      end else begin
        if (exp_busy && cyc == done_at) exp_busy = 1'b0;
        if (cyc >= free_at && tx_ready && (|req_valid)) begin
          win = pick(req_valid, next_start);
`ifdef CAN_TX_SCHED_RR_EN
          next_start = (win + 1) % N;
`endif
          d    = req_data[32*win +: 32];
          hold = choose_hold();
          tv   = cyc + 1;                    // issue pulse shows the cycle after the accept
          if (hold == 0) begin
            done_at = tv + BW;               // no acknowledge within BUSY_WAIT cycles of the issue
            err     = 1'b1;
          end else begin
            wd_entry = tv + 2;               // core drops tx_ready next cycle; seen one cycle later
            done_at  = wd_entry + ((hold < TO) ? hold : TO);
            err      = (hold > TO);
          end
          gq.push_back('{win, d, cyc});
          tq.push_back('{win, d, tv});
          dq.push_back('{win, err, done_at});
          mode_q.push_back(hold);
          free_at  = done_at + 1;
          exp_busy = 1'b1;
          exp_data = d;
        end
      end
    end
  end

  // CAN core model: drops tx_ready the cycle after the issue pulse for the chosen hold time
  initial begin : core
    int   hold;
    int   remain;
    logic pend;
    tx_ready = 1'b1;
    hold     = 1;
    remain   = 0;
    pend     = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && tx_valid) begin
        pend = 1'b1;
        hold = (mode_q.size() > 0) ? mode_q.pop_front() : 1;
      end
      @(posedge ap_clk);
      #1;
      if (!ap_rst_n) begin
        tx_ready = 1'b1;
        remain   = 0;
        pend     = 1'b0;
      end else if (pend) begin
        pend = 1'b0;
        if (hold > 0) begin
          tx_ready = 1'b0;
          remain   = hold;
        end
      end else if (remain > 0) begin
        remain--;
        if (remain == 0) tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an accept, issue or done pulse
  initial begin : monitor
    xfer_t g;
    done_t e;
    int    gi;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        ack_seen = '0;
      end else begin
        ack_seen = req_ready;
        if (req_ready != '0) begin
          if (gq.size() == 0) begin
            flag("unexpected_grant", $sformatf("req_ready=%b, required none", req_ready));
          end else begin
            g = gq.pop_front();
            check("grant_onehot", 64'(req_ready), 64'(1) << g.idx);
            check("grant_cycle", 64'(cyc), 64'(g.at));
            check("grant_data", 64'(tx_data), 64'(g.data));
          end
          gi = -1;
          for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
          if (phase == 1) clog.push_back(gi);
        end
        while (gq.size() > 0 && gq[0].at < cyc) begin
          g = gq.pop_front();
          flag("missed_grant", $sformatf("no req_ready, required idx %0d at cycle %0d", g.idx, g.at));
        end
        if (tx_valid) begin
          if (tq.size() == 0) begin
            flag("unexpected_tx_valid", "tx_valid=1, required 0");
          end else begin
            g = tq.pop_front();
            check("tx_data_issue", 64'(tx_data), 64'(g.data));
            check("tx_cycle", 64'(cyc), 64'(g.at));
          end
        end
        while (tq.size() > 0 && tq[0].at < cyc) begin
          g = tq.pop_front();
          flag("missed_tx_valid", $sformatf("no tx_valid, required at cycle %0d", g.at));
        end
        if (done_valid) begin
          done_cnt++;
          last_done_idx = int'(done_idx);
          last_done_err = done_err;
          if (dq.size() == 0) begin
            flag("unexpected_done", $sformatf("done_valid=1 idx=%0d err=%0d, required none", done_idx, done_err));
          end else begin
            e = dq.pop_front();
            check("done_idx", 64'(done_idx), 64'(e.idx));
            check("done_err", 64'(done_err), 64'(e.err));
            check("done_cycle", 64'(cyc), 64'(e.at));
          end
        end
        while (dq.size() > 0 && dq[0].at < cyc) begin
          e = dq.pop_front();
          flag("missed_done", $sformatf("no done_valid, required idx %0d at cycle %0d", e.idx, e.at));
        end
        if (done_valid || req_ready != '0) check("ready_done_excl", 64'(done_valid && (|req_ready)), 64'(0));
        check("busy", 64'(busy), 64'(exp_busy));
        check("tx_data_hold", 64'(tx_data), 64'(exp_data));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
    check({tag, "_done_valid"}, 64'(done_valid), 64'(0));
    check({tag, "_done_err"}, 64'(done_err), 64'(0));
    check({tag, "_done_idx"}, 64'(done_idx), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_tx_data"}, 64'(tx_data), 64'(0));
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        else req_data[32*i +: 32] = $urandom();
      end else if (req_valid[i]) begin
        if ($urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[32*i +: 32] = $urandom();
      end
    end
  endtask

  task automatic wait_ack(input int i, input string name);
    int t;
    t = 0;
    while (!ack_seen[i] && t < 400) begin
      @(posedge ap_clk);
      #1;
      t++;
    end
    if (!ack_seen[i]) flag(name, $sformatf("no req_ready[%0d] within 400 cycles", i));
  endtask

  // Stimulus: contention, directed single frame, random traffic, reset mid-frame, random traffic
  initial begin : main
    int exp_seq[5];
    int base;
`ifdef CAN_TX_SCHED_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    ap_rst_n  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    #2 ap_rst_n = 1'b0;
    #1 check_all_zero("reset_init");
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;

    // Contention: everyone pending continuously
    phase = 1;
    @(posedge ap_clk);
    #1;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom();
    for (int t = 0; t < 300 && clog.size() < 5; t++) begin
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < N; i++) if (ack_seen[i]) req_data[32*i +: 32] = $urandom();
    end
    if (clog.size() < 5) flag("contention_grants", $sformatf("%0d grants seen, required 5", clog.size()));
    else for (int k = 0; k < 5; k++) check($sformatf("contention_order_%0d", k), 64'(clog[k]), 64'(exp_seq[k]));
    req_valid = '0;
    repeat (20) @(posedge ap_clk);
    #1;

    // Directed single request on lane 2
    phase = 2;
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'hDEADBEEF;
    wait_ack(2, "directed_grant");
    req_valid = '0;
    repeat (40) @(posedge ap_clk);
    #1;
    check("directed_done_idx", 64'(last_done_idx), 64'(2));
    check("directed_done_err", 64'(last_done_err), 64'(0));
    check("directed_tx_data", 64'(tx_data), 64'(32'hDEADBEEF));

    // Random traffic with normal, late, stuck and no-ack cores
    phase = 3;
    repeat (3000) begin
      rand_step();
      @(posedge ap_clk);
      #1;
    end
    req_valid = '0;
    repeat (200) @(posedge ap_clk);
    #1;

    // Reset while a frame is in WAIT_DONE
    phase = 4;
    req_valid[1] = 1'b1;
    req_data[32 +: 32] = $urandom();
    wait_ack(1, "reset_frame_grant");
    req_valid = '0;
    repeat (40) @(posedge ap_clk);
    @(negedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1 check_all_zero("reset_mid_frame");
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    base = done_cnt;
    repeat (30) @(posedge ap_clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt - base), 64'(0));

    phase = 5;
    repeat (1500) begin
      rand_step();
      @(posedge ap_clk);
      #1;
    end
    req_valid = '0;
    repeat (250) @(posedge ap_clk);
    #1;
    check("scoreboard_drained", 64'(gq.size() + tq.size() + dq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_tx_sched.md
CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of transmit requesters (2..8).
REQ-002 Parameter TX_TIMEOUT, default 50000: max cycles allowed for a frame to complete once issued.
REQ-003 Parameter BUSY_WAIT, default 16: max cycles allowed for the core to deassert tx_ready after the issue pulse.
REQ-004 ap_clk  in  1  single clock; all logic on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester frame-pending flag.
REQ-007 req_data  in  32*NUM_REQ  per-requester payload word; requester i occupies bits [32*i+31:32*i].
REQ-008 req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-009 tx_data  out  32  payload presented to the CAN core.
REQ-010 tx_valid  out  1  single-cycle issue pulse to the CAN core.
REQ-011 tx_ready  in  1  CAN core idle flag; low while a frame is in flight.
REQ-012 done_valid  out  1  one-cycle pulse when a frame completes or aborts.
REQ-013 done_idx  out  clog2(NUM_REQ)  requester index reported with done_valid.
REQ-014 done_err  out  1  qualifies done_valid; 1 = timeout abort.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE: when any req_valid is set and tx_ready=1, select a winner, latch its req_data into tx_data, pulse req_ready[winner] in that same cycle, and move to ISSUE.
REQ-018 IDLE with tx_ready=0 SHALL NOT grant, even if requests are pending.
REQ-019 ISSUE: assert tx_valid for exactly one cycle (0 before and after), clear the cycle counter, and move to WAIT_BUSY.
REQ-020 WAIT_BUSY: on tx_ready=0 move to WAIT_DONE and clear the counter; if BUSY_WAIT cycles elapse first, abort.
REQ-021 WAIT_DONE: on tx_ready=1 pulse done_valid with done_err=0 and done_idx=winner, then return to IDLE; if TX_TIMEOUT cycles elapse first, abort.
REQ-022 Abort SHALL pulse done_valid with done_err=1 and done_idx=winner, then return to IDLE; the frame is not retried.
REQ-023 The cycle counter SHALL be 32 bits wide, saturate rather than wrap, and compare with >= against the parameter.
REQ-024 tx_data SHALL hold its latched value from the grant cycle until the next grant.
REQ-025 Minimum grant-to-grant spacing is 4 cycles: grant, ISSUE, WAIT_BUSY, WAIT_DONE-exit.
REQ-026 A requester that deasserts req_valid before being granted SHALL lose its pending request without a side effect.
REQ-027 done_valid and req_ready SHALL never be asserted in the same cycle.

Reset
REQ-028 On ap_rst_n=0, SHALL force immediately: state=IDLE, tx_valid=0, req_ready=0, done_valid=0, done_err=0, done_idx=0, busy=0, tx_data=0, counter=0, round-robin pointer=0.
REQ-029 A reset during WAIT_DONE SHALL discard the in-flight frame with no done_valid pulse after reset release.

Configuration
REQ-030 With CAN_TX_SCHED_RR_EN defined, the winner SHALL be chosen round-robin: search starts at the index after the last winner and wraps NUM_REQ-1 to 0.
REQ-031 Without CAN_TX_SCHED_RR_EN, the winner SHALL be chosen by fixed priority, lowest index wins.

Structure
REQ-032 Shared package can_pkg SHALL hold the FSM state enum, CAN_WORD_W=32 and the default timeout constants.
REQ-033 Winner selection SHALL live in sub-module can_tx_sched_pick, which takes the request vector and last-winner pointer and returns a one-hot grant.

Verification
REQ-034 Single request: req_valid=4'b0100, data 0xDEADBEEF, tx_ready=1 -> req_ready=4'b0100 in cycle 0, tx_valid and tx_data=0xDEADBEEF in cycle 1; core holds tx_ready low 20 cycles -> done_valid, done_idx=2, done_err=0.
REQ-035 Contention, all 4 valid continuously: RR build grants in order 0,1,2,3,0; fixed-priority build grants 0 every time.
REQ-036 Stuck core: tx_ready stays 0 after issue, TX_TIMEOUT=100 -> done_err=1 pulse exactly 100 cycles after WAIT_DONE entry, then the next grant proceeds.
REQ-037 No-ack core: tx_ready never drops after tx_valid, BUSY_WAIT=16 -> abort with done_err=1 after 16 cycles.
REQ-038 Core busy at request: tx_ready=0 when req_valid=4'b0001 rises -> no req_ready until tx_ready=1, then a grant in that same cycle.
REQ-039 Reset asserted mid-WAIT_DONE -> all outputs 0 asynchronously, and no done_valid after release.
